// File: rtl/retire_rob.sv
// In-order retire buffer: ISSUE allocates in program order, NUM_SRC units complete by tag,
// ARF writeback drains strictly in order. Optional same-cycle completion bypass: RETIRE_CMP_BYPASS_EN.

module rob_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc,
  input  logic [4:0]      alloc_rd,
  input  logic            alloc_writes_rd,
  input  logic            cmp,
  input  logic [XLEN-1:0] cmp_data,
  input  logic            retire,
  output logic            valid,
  output logic            done,
  output logic [4:0]      rd,
  output logic            writes_rd,
  output logic [XLEN-1:0] data
);
  // Retire outranks a completion so a bypassed head never lingers as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      done      <= 1'b0;
      rd        <= '0;
      writes_rd <= 1'b0;
      data      <= '0;
    end else if (flush || retire) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc) begin
      valid     <= 1'b1;
      done      <= 1'b0;
      rd        <= alloc_rd;
      writes_rd <= alloc_writes_rd;
    end else if (cmp) begin
      done <= 1'b1;
      data <= cmp_data;
    end
  end
endmodule

module retire_rob #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_alloc_valid,
  input  logic [4:0]               i_alloc_rd,
  input  logic                     i_alloc_writes_rd,
  output logic                     o_alloc_ready,
  output logic [TAG_W-1:0]         o_alloc_tag,
  input  logic [NUM_SRC-1:0]       i_cmp_valid,
  input  logic [NUM_SRC*TAG_W-1:0] i_cmp_tag,
  input  logic [NUM_SRC*XLEN-1:0]  i_cmp_data,
  input  logic                     i_flush,
  input  logic                     i_stall,
  output logic                     o_wb_en,
  output logic [4:0]               o_wb_rd,
  output logic [XLEN-1:0]          o_wb_data,
  output logic                     o_fwd_writes_rd,
  output logic [4:0]               o_fwd_rd,
  output logic [XLEN-1:0]          o_fwd_data,
  output logic                     o_cmp_err,
  output logic [TAG_W:0]           o_count,
  output logic [31:0]              o_instret
);
  logic [TAG_W:0]               head, tail, count;
  logic [TAG_W-1:0]             head_idx, tail_idx;
  logic                         full, alloc_fire, fire;
  logic                         head_valid, head_done, head_ready;
  logic [XLEN-1:0]              head_data;
  logic                         err_now, cmp_err_q;
  logic [31:0]                  instret;

  logic [DEPTH-1:0]             e_valid, e_done, e_wr;
  logic [DEPTH-1:0][4:0]        e_rd;
  logic [DEPTH-1:0][XLEN-1:0]   e_data;
  logic [DEPTH-1:0]             cmp_we;
  logic [DEPTH-1:0][XLEN-1:0]   cmp_wdata;

  logic [NUM_SRC-1:0][TAG_W-1:0] src_tag;
  logic [NUM_SRC-1:0][XLEN-1:0]  src_data;
  logic [NUM_SRC-1:0]            dup;

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign count      = tail - head;
  assign full       = (count == (TAG_W+1)'(DEPTH));
  assign alloc_fire = i_alloc_valid && o_alloc_ready;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src_tag[s]  = i_cmp_tag[s*TAG_W +: TAG_W];
    assign src_data[s] = i_cmp_data[s*XLEN +: XLEN];
  end

  // A source loses when any lower-numbered source targets the same tag this cycle.
  always_comb begin
    dup = '0;
    for (int s = 1; s < NUM_SRC; s++)
      for (int p = 0; p < s; p++)
        if (i_cmp_valid[p] && i_cmp_valid[s] && (src_tag[p] == src_tag[s]))
          dup[s] = 1'b1;
  end

  always_comb begin
    cmp_we    = '0;
    cmp_wdata = '0;
    err_now   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (i_cmp_valid[s]) begin
        if (dup[s] || !e_valid[src_tag[s]] || e_done[src_tag[s]]) begin
          err_now = 1'b1;
        end else begin
          cmp_we[src_tag[s]]    = 1'b1;
          cmp_wdata[src_tag[s]] = src_data[s];
        end
      end
    end
    if (i_flush) begin
      cmp_we  = '0;
      err_now = 1'b0;
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_entry #(.XLEN(XLEN)) u_ent (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (i_flush),
      .alloc           (alloc_fire && (tail_idx == TAG_W'(e))),
      .alloc_rd        (i_alloc_rd),
      .alloc_writes_rd (i_alloc_writes_rd),
      .cmp             (cmp_we[e]),
      .cmp_data        (cmp_wdata[e]),
      .retire          (fire && (head_idx == TAG_W'(e))),
      .valid           (e_valid[e]),
      .done            (e_done[e]),
      .rd              (e_rd[e]),
      .writes_rd       (e_wr[e]),
      .data            (e_data[e])
    );
  end

  assign head_valid = e_valid[head_idx];
  assign head_done  = e_done[head_idx];

`ifdef RETIRE_CMP_BYPASS_EN
  // cmp_we on the head already implies valid && !done, so it doubles as the bypass hit.
  assign head_ready = head_done || cmp_we[head_idx];
  assign head_data  = head_done ? e_data[head_idx] : cmp_wdata[head_idx];
`else
  assign head_ready = head_done;
  assign head_data  = e_data[head_idx];
`endif

  assign fire = head_valid && head_ready && !i_stall && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      instret   <= '0;
      cmp_err_q <= 1'b0;
    end else begin
      cmp_err_q <= err_now;
      if (i_flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (alloc_fire) tail <= tail + 1'b1;
        if (fire)       head <= head + 1'b1;
      end
      if (fire) instret <= instret + 32'd1;
    end
  end

  assign o_alloc_ready   = !full && !i_flush;
  assign o_alloc_tag     = tail_idx;
  assign o_wb_en         = fire && e_wr[head_idx] && (e_rd[head_idx] != 5'd0);
  assign o_wb_rd         = fire ? e_rd[head_idx] : 5'd0;
  assign o_wb_data       = fire ? head_data : '0;
  assign o_fwd_writes_rd = o_wb_en;
  assign o_fwd_rd        = o_wb_rd;
  assign o_fwd_data      = o_wb_data;
  assign o_cmp_err       = cmp_err_q;
  assign o_count         = count;
  assign o_instret       = instret;
endmodule

// File: tb/tb_retire_rob.sv
// Directed table-driven bench for retire_rob (default build, NUM_SRC=2, DEPTH=4).
module tb_retire_rob;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     alloc_valid, alloc_writes_rd, alloc_ready;
  logic [4:0]               alloc_rd;
  logic [TAG_W-1:0]         alloc_tag;
  logic [NUM_SRC-1:0]       cmp_valid;
  logic [NUM_SRC*TAG_W-1:0] cmp_tag;
  logic [NUM_SRC*XLEN-1:0]  cmp_data;
  logic                     flush, stall;
  logic                     wb_en, fwd_writes_rd, cmp_err;
  logic [4:0]               wb_rd, fwd_rd;
  logic [XLEN-1:0]          wb_data, fwd_data;
  logic [TAG_W:0]           count;
  logic [31:0]              instret;

  retire_rob #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd), .i_alloc_writes_rd(alloc_writes_rd),
    .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
    .i_cmp_valid(cmp_valid), .i_cmp_tag(cmp_tag), .i_cmp_data(cmp_data),
    .i_flush(flush), .i_stall(stall),
    .o_wb_en(wb_en), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_fwd_writes_rd(fwd_writes_rd), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data),
    .o_cmp_err(cmp_err), .o_count(count), .o_instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        awr;
    logic [1:0]  cv;
    logic [1:0]  ct0, ct1;
    logic [31:0] cd0, cd1;
    logic        fl, st;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        rdy;
    logic [1:0]  tag;
    logic [2:0]  cnt;
    logic        err;
    logic [31:0] ir;
  } vec_t;

  vec_t v[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic awr,
    input logic [1:0] cv, input logic [1:0] ct0, input logic [1:0] ct1,
    input logic [31:0] cd0, input logic [31:0] cd1, input logic fl, input logic st,
    input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
    input logic rdy, input logic [1:0] tag, input logic [2:0] cnt,
    input logic err, input logic [31:0] ir);
    vec_t r;
    r.av = av; r.ard = ard; r.awr = awr; r.cv = cv; r.ct0 = ct0; r.ct1 = ct1;
    r.cd0 = cd0; r.cd1 = cd1; r.fl = fl; r.st = st;
    r.wen = wen; r.wrd = wrd; r.wdata = wdata; r.rdy = rdy; r.tag = tag;
    r.cnt = cnt; r.err = err; r.ir = ir;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd = '0; alloc_writes_rd = 1'b0;
    cmp_valid = '0; cmp_tag = '0; cmp_data = '0; flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    //          av ard  awr cv     ct0 ct1 cd0            cd1    fl st | wen rd  data          rdy tag cnt err ir
    v.push_back(mk(1, 5,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  0,  0,  0));
    v.push_back(mk(0, 0,  0, 2'b01, 0, 0, 32'hDEADBEEF,  0,     0, 0,   0, 0,  0,            1,  1,  1,  0,  0));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 5,  32'hDEADBEEF, 1,  1,  1,  0,  0));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  1,  0,  0,  1));
    // out-of-order completion, in-order retire
    v.push_back(mk(1, 1,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  1,  0,  0,  1));
    v.push_back(mk(1, 2,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  2,  1,  0,  1));
    v.push_back(mk(1, 3,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  3,  2,  0,  1));
    v.push_back(mk(0, 0,  0, 2'b01, 3, 0, 32'h33,        0,     0, 0,   0, 0,  0,            1,  0,  3,  0,  1));
    v.push_back(mk(0, 0,  0, 2'b10, 0, 2, 0,             32'h22,0, 0,   0, 0,  0,            1,  0,  3,  0,  1));
    v.push_back(mk(0, 0,  0, 2'b01, 1, 0, 32'h11,        0,     0, 0,   0, 0,  0,            1,  0,  3,  0,  1));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 1,  32'h11,       1,  0,  3,  0,  1));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 2,  32'h22,       1,  0,  2,  0,  2));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 3,  32'h33,       1,  0,  1,  0,  3));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  0,  0,  4));
    // fill to DEPTH, refused alloc while full, tag wrap 3 -> 0
    v.push_back(mk(1, 6,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  0,  0,  4));
    v.push_back(mk(1, 7,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  1,  1,  0,  4));
    v.push_back(mk(1, 8,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  2,  2,  0,  4));
    v.push_back(mk(1, 9,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  3,  3,  0,  4));
    v.push_back(mk(1, 10, 1, 2'b01, 0, 0, 32'h60,        0,     0, 0,   0, 0,  0,            0,  0,  4,  0,  4));
    v.push_back(mk(1, 10, 1, 2'b00, 0, 0, 0,             0,     0, 0,   1, 6,  32'h60,       0,  0,  4,  0,  4));
    v.push_back(mk(1, 10, 1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  3,  0,  5));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            0,  1,  4,  0,  5));
    // same-tag dual completion: source 0 wins, error pulse
    v.push_back(mk(0, 0,  0, 2'b11, 1, 1, 32'h11,        32'h22,0, 0,   0, 0,  0,            0,  1,  4,  0,  5));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 7,  32'h11,       0,  1,  4,  1,  5));
    // completion to a now-invalid tag
    v.push_back(mk(0, 0,  0, 2'b01, 1, 0, 32'h99,        0,     0, 0,   0, 0,  0,            1,  1,  3,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  1,  3,  1,  6));
    // flush with a done head and an alloc attempt
    v.push_back(mk(0, 0,  0, 2'b01, 2, 0, 32'h88,        0,     0, 0,   0, 0,  0,            1,  1,  3,  0,  6));
    v.push_back(mk(1, 12, 1, 2'b00, 0, 0, 0,             0,     1, 0,   0, 0,  0,            0,  1,  3,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  0,  0,  6));
    // stall a done head for three cycles
    v.push_back(mk(1, 13, 1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  0,  0,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b01, 0, 0, 32'h77,        0,     0, 1,   0, 0,  0,            1,  1,  1,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 1,   0, 0,  0,            1,  1,  1,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 1,   0, 0,  0,            1,  1,  1,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 1,   0, 0,  0,            1,  1,  1,  0,  6));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   1, 13, 32'h77,       1,  1,  1,  0,  6));
    // rd=0 uop retires without a write but counts
    v.push_back(mk(1, 0,  1, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  1,  0,  0,  7));
    v.push_back(mk(0, 0,  0, 2'b01, 1, 0, 32'h55,        0,     0, 0,   0, 0,  0,            1,  2,  1,  0,  7));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  32'h55,       1,  2,  1,  0,  7));
    v.push_back(mk(0, 0,  0, 2'b00, 0, 0, 0,             0,     0, 0,   0, 0,  0,            1,  2,  0,  0,  8));

    idle_inputs();
    #3;
    chk("rst_wb_en", -1, 32'(wb_en), 0);
    chk("rst_wb_data", -1, wb_data, 0);
    chk("rst_ready", -1, 32'(alloc_ready), 1);
    chk("rst_tag", -1, 32'(alloc_tag), 0);
    chk("rst_count", -1, 32'(count), 0);
    chk("rst_err", -1, 32'(cmp_err), 0);
    chk("rst_instret", -1, instret, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      @(posedge clk);
      #1;
      alloc_valid = v[i].av; alloc_rd = v[i].ard; alloc_writes_rd = v[i].awr;
      cmp_valid = v[i].cv; cmp_tag = {v[i].ct1, v[i].ct0}; cmp_data = {v[i].cd1, v[i].cd0};
      flush = v[i].fl; stall = v[i].st;
      @(negedge clk);
      chk("wb_en",    i, 32'(wb_en),         32'(v[i].wen));
      chk("wb_rd",    i, 32'(wb_rd),         32'(v[i].wrd));
      chk("wb_data",  i, wb_data,            v[i].wdata);
      chk("fwd_wr",   i, 32'(fwd_writes_rd), 32'(v[i].wen));
      chk("fwd_rd",   i, 32'(fwd_rd),        32'(v[i].wrd));
      chk("fwd_data", i, fwd_data,           v[i].wdata);
      chk("ready",    i, 32'(alloc_ready),   32'(v[i].rdy));
      chk("tag",      i, 32'(alloc_tag),     32'(v[i].tag));
      chk("count",    i, 32'(count),         32'(v[i].cnt));
      chk("cmp_err",  i, 32'(cmp_err),       32'(v[i].err));
      chk("instret",  i, instret,            v[i].ir);
    end

    // asynchronous reset mid-operation: state drops without a clock edge
    @(posedge clk);
    #1;
    idle_inputs();
    alloc_valid = 1'b1; alloc_rd = 5'd3; alloc_writes_rd = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("pre_arst_count", 100, 32'(count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 101, 32'(count), 0);
    chk("arst_instret", 101, instret, 0);
    chk("arst_ready", 101, 32'(alloc_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
